bus_rr_mux: RTL and testbench

- Parametrised, registered successor to the datapath bus mux.
- Instead of a static one-hot select, NCH requesters contend for one shared WIDTH-bit bus. A round-robin arbiter picks one per cycle and captures its word into an output register.
- The register is drained through a valid/ready handshake.
- Sits between the datapath sources (PC, MDR, ALU, MARMUX, future peripherals) and the consumer of the shared bus.

---
 rtl/bus_rr_mux.sv | 84 ++++++++
 tb/tb_bus_rr_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_mux.sv
// Round-robin arbitrated bus mux: NCH requesters share one WIDTH-bit bus through
// a single output register drained with a valid/ready handshake.
module bus_rr_mux #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] din,
    output logic [NCH-1:0]       grant,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    state_t           state;
    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  win;
    logic             hit;
    logic             cap_en;
    logic             capture;
    logic [WIDTH-1:0] chan [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign chan[i] = din[i*WIDTH +: WIDTH];
    end

    // Rotating priority search: the first set request at or after ptr wins.
    always_comb begin
        logic [SELW:0] idx;
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        win = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, ptr} + (SELW+1)'(k);
            if (idx >= NCH_W) begin
                idx = idx - NCH_W;
            end
            if (!hit && req[idx[SELW-1:0]]) begin
                hit = 1'b1;
                win = idx[SELW-1:0];
            end
        end
    end

    // out_ready reaches only the capture decision, never the registered outputs.
    assign cap_en    = (state == EMPTY) || out_ready;
    assign capture   = cap_en && hit;
    assign out_valid = (state == FULL);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= EMPTY;
            ptr      <= '0;
            grant    <= '0;
            out_data <= '0;
            out_sel  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            grant <= '0;
            if (capture) begin
                state    <= FULL;
                out_data <= chan[win];
                out_sel  <= win;
                grant    <= NCH'(1) << win;
                ptr      <= (win == SELW'(NCH-1)) ? '0 : win + 1'b1;
            end else if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_bus_rr_mux.sv
// Bench for bus_rr_mux: three parameterisations driven from one stimulus stream and
// compared every cycle against a behavioural round-robin model.
module tb_bus_rr_mux;

    localparam int NI = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] r = '0;
    logic [31:0] d [16];

    logic [3:0]   req_a;
    logic [63:0]  din_a;
    logic [3:0]   grant_a;
    logic [15:0]  data_a;
    logic [1:0]   sel_a;
    logic         valid_a;

    logic [1:0]   req_b;
    logic [15:0]  din_b;
    logic [1:0]   grant_b;
    logic [7:0]   data_b;
    logic [0:0]   sel_b;
    logic         valid_b;

    logic [4:0]   req_c;
    logic [159:0] din_c;
    logic [4:0]   grant_c;
    logic [31:0]  data_c;
    logic [2:0]   sel_c;
    logic         valid_c;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state, one slot per instance.
    int          nch   [NI] = '{4, 2, 5};
    logic [31:0] dmask [NI] = '{32'h0000_FFFF, 32'h0000_00FF, 32'hFFFF_FFFF};
    string       nm    [NI] = '{"a", "b", "c"};
    bit          m_valid [NI];
    logic [31:0] m_data  [NI];
    int          m_sel   [NI];
    int          m_ptr   [NI];
    logic [15:0] m_grant [NI];

    always #5 Clk = ~Clk;

    assign req_a = r[3:0];
    assign req_b = r[1:0];
    assign req_c = r[4:0];

    always_comb begin
        din_a = '0;
        din_b = '0;
        din_c = '0;
        for (int i = 0; i < 4; i++) din_a[i*16 +: 16] = d[i][15:0];
        for (int i = 0; i < 2; i++) din_b[i*8 +: 8]   = d[i][7:0];
        for (int i = 0; i < 5; i++) din_c[i*32 +: 32] = d[i];
    end

    bus_rr_mux #(.WIDTH(16), .NCH(4)) dut_a (
        .Clk(Clk), .Reset(Reset), .req(req_a), .din(din_a), .grant(grant_a),
        .out_data(data_a), .out_sel(sel_a), .out_valid(valid_a), .out_ready(rdy)
    );

    bus_rr_mux #(.WIDTH(8), .NCH(2)) dut_b (
        .Clk(Clk), .Reset(Reset), .req(req_b), .din(din_b), .grant(grant_b),
        .out_data(data_b), .out_sel(sel_b), .out_valid(valid_b), .out_ready(rdy)
    );

    bus_rr_mux #(.WIDTH(32), .NCH(5)) dut_c (
        .Clk(Clk), .Reset(Reset), .req(req_c), .din(din_c), .grant(grant_c),
        .out_data(data_c), .out_sel(sel_c), .out_valid(valid_c), .out_ready(rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int i, input int f);
        logic [31:0] v;
        v = '0;
        case (i)
            0: case (f) 0: v = 32'(data_a); 1: v = 32'(sel_a); 2: v = 32'(valid_a); default: v = 32'(grant_a); endcase
            1: case (f) 0: v = 32'(data_b); 1: v = 32'(sel_b); 2: v = 32'(valid_b); default: v = 32'(grant_b); endcase
            default: case (f) 0: v = data_c; 1: v = 32'(sel_c); 2: v = 32'(valid_c); default: v = 32'(grant_c); endcase
        endcase
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            m_sel[i]   = 0;
            m_ptr[i]   = 0;
            m_grant[i] = '0;
        end
    endtask

    // One clock edge of the spec's rules, evaluated from the inputs as they stand now.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            int  w;
            bit  cap;
            w   = -1;
            cap = !m_valid[i] || rdy;
            for (int k = 0; k < nch[i]; k++) begin
                int idx;
                idx = (m_ptr[i] + k) % nch[i];
                if (w < 0 && r[idx]) w = idx;
            end
            m_grant[i] = '0;
            if (cap && w >= 0) begin
                m_data[i]  = d[w] & dmask[i];
                m_sel[i]   = w;
                m_valid[i] = 1'b1;
                m_grant[i] = 16'(1) << w;
                m_ptr[i]   = (w + 1) % nch[i];
            end else if (m_valid[i] && rdy) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check({nm[i], ".data"},  obs(i, 0), m_data[i]);
            check({nm[i], ".sel"},   obs(i, 1), 32'(m_sel[i]));
            check({nm[i], ".valid"}, obs(i, 2), 32'(m_valid[i]));
            check({nm[i], ".grant"}, obs(i, 3), 32'(m_grant[i]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        cyc++;
        check_all();
    endtask

    // Raises Reset between edges, checks the immediate effect, holds it across an edge.
    task automatic do_reset();
        #2 Reset = 1'b1;
        model_reset();
        #1 check_all();
        @(posedge Clk);
        #1 check_all();
        check("rst.grant_a_held", 32'(grant_a), 32'h0);
        Reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) d[i] = '0;
        do_reset();

        // Single requester on channel 2, then release.
        rdy  = 1'b1;
        r    = 16'h0004;
        d[2] = 32'h0000_BEEF;
        step();
        check("single.grant_a", 32'(grant_a), 32'h4);
        check("single.data_a",  32'(data_a),  32'hBEEF);
        check("single.sel_a",   32'(sel_a),   32'd2);
        r = '0;
        step();
        check("single.valid_a_drop", 32'(valid_a), 32'h0);
        check("single.data_a_kept",  32'(data_a),  32'hBEEF);

        // Round robin with every channel requesting continuously.
        do_reset();
        r = 16'hFFFF;
        for (int i = 0; i < 16; i++) d[i] = 32'h1000 + 32'(i);
        for (int k = 0; k < 6; k++) begin
            step();
            check("rr.sel_a",   32'(sel_a),   32'(k % 4));
            check("rr.grant_a", 32'(grant_a), 32'(1) << (k % 4));
            check("rr.sel_b",   32'(sel_b),   32'(k % 2));
            check("rr.sel_c",   32'(sel_c),   32'(k % 5));
        end

        // Backpressure: hold channel 1's word while channels 0 and 3 wait.
        do_reset();
        r    = 16'h0002;
        d[1] = 32'h0000_00A1;
        step();
        r   = 16'h0009;
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp.data_a",  32'(data_a),  32'h00A1);
            check("bp.grant_a", 32'(grant_a), 32'h0);
        end
        rdy = 1'b1;
        step();
        check("bp.sel_a_ch3", 32'(sel_a), 32'd3);

        // Wrap to channel 0, then withdraw channel 1 before it is granted.
        r = 16'h0003;
        step();
        check("wrap.sel_a_ch0", 32'(sel_a), 32'd0);
        r = '0;
        step();
        check("wd.grant_a", 32'(grant_a), 32'h0);
        check("wd.valid_a", 32'(valid_a), 32'h0);

        // Randomised traffic with sporadic backpressure.
        for (int k = 0; k < 400; k++) begin
            r   = 16'($urandom) & 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 16; i++) d[i] = $urandom;
            step();
        end

        // Reset landing while a word is stalled in the register.
        r   = 16'h0004;
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        step();
        check("rst.valid_a_before", 32'(valid_a), 32'h1);
        do_reset();
        check("rst.valid_a_after", 32'(valid_a), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
